// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch-stage control, instruction-memory port and IF/ID outputs
interface if_fetch_stage_if #(parameter int pc_width = 10, parameter int instr_width = 16);
  logic stall;
  logic redirect;
  logic [pc_width-1:0] redirect_pc;
  logic [pc_width-1:0] imem_addr;
  logic imem_en;
  logic [instr_width-1:0] imem_rdata;
  logic [pc_width-1:0] pc_curr_if;
  logic [instr_width-1:0] instr_if;
  logic halted;
  modport master (
    input stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, imem_en, pc_curr_if, instr_if, halted
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input imem_addr, imem_en, pc_curr_if, instr_if, halted
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and 1-cycle-latency imem driver with boot, stall, redirect squash and HALT;
// define IF_IMEM_GATE_EN to drop imem_en while stalled or halted.
module if_fetch_stage #(
  parameter int pc_width = 10,
  parameter int instr_width = 16,
  parameter logic [pc_width-1:0] reset_pc = '0,
  parameter logic [instr_width-1:0] nop_instr = '0,
  parameter logic [instr_width-1:0] halt_instr = '1
) (
  input logic clk,
  input logic rst,
  if_fetch_stage_if.master f
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [pc_width-1:0] pc_q, pc_n, addr;
  logic vld_q, halt_take;
  always_comb begin
    halt_take = state == RUN && vld_q && !f.stall && !f.redirect && f.imem_rdata == halt_instr;
    addr = state == HALT ? (f.redirect ? f.redirect_pc : pc_q)
         : state == RUN ? (f.redirect ? f.redirect_pc : f.stall ? pc_q : pc_q + pc_width'(1))
         : reset_pc;
    state_n = state == BOOT ? RUN
            : halt_take ? HALT
            : state == HALT && !f.redirect ? HALT
            : RUN;
    pc_n = halt_take ? pc_q : addr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_q <= reset_pc;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      vld_q <= state_n == RUN;
    end
  end
  assign f.imem_addr = rst ? reset_pc : addr;
`ifdef IF_IMEM_GATE_EN
  assign f.imem_en = rst || !(state == RUN ? f.stall && !f.redirect : state == HALT && !f.redirect);
`else
  assign f.imem_en = 1'b1;
`endif
  assign f.pc_curr_if = pc_q;
  assign f.instr_if = (state == RUN && vld_q && !f.redirect) ? f.imem_rdata : nop_instr;
  assign f.halted = state == HALT;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of boot, stall, redirect, halt, wrap and mid-run reset
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [15:0] rom [1024];
  if_fetch_stage_if b ();
  if_fetch_stage dut (.clk(clk), .rst(rst), .f(b.master));
  always #5 clk = ~clk;
  always @(posedge clk) if (b.imem_en) b.imem_rdata <= rom[b.imem_addr];
`ifdef IF_IMEM_GATE_EN
  localparam logic gated = 1'b1;
`else
  localparam logic gated = 1'b0;
`endif
  task automatic tick(input logic s, input logic r, input logic [9:0] p);
    @(negedge clk);
    b.stall = s;
    b.redirect = r;
    b.redirect_pc = p;
    #1;
  endtask
  task automatic test_reset;
    b.stall = 0; b.redirect = 0; b.redirect_pc = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (b.imem_addr !== 10'h000 || b.imem_en !== 1'b1 || b.pc_curr_if !== 10'h000) begin
      errors++; $display("FAIL rst_hold addr=%h en=%b pc=%h want 000/1/000", b.imem_addr, b.imem_en, b.pc_curr_if);
    end
    rst = 0;
    #1;
    checks++;
    if (b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h0000 || b.halted !== 1'b0 || b.imem_addr !== 10'h000) begin
      errors++; $display("FAIL boot_slot pc=%h instr=%h halted=%b addr=%h want 000/0000/0/000", b.pc_curr_if, b.instr_if, b.halted, b.imem_addr);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h1000) begin
      errors++; $display("FAIL first_instr pc=%h instr=%h want 000/1000", b.pc_curr_if, b.instr_if);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h001 || b.instr_if !== 16'h1001) begin
      errors++; $display("FAIL second_instr pc=%h instr=%h want 001/1001", b.pc_curr_if, b.instr_if);
    end
  endtask
  task automatic test_stall;
    repeat (3) tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h004 || b.instr_if !== 16'h1004) begin
      errors++; $display("FAIL seq_pc4 pc=%h instr=%h want 004/1004", b.pc_curr_if, b.instr_if);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, 0, 0);
      checks++;
      if (b.pc_curr_if !== 10'h005 || b.instr_if !== 16'h1005) begin
        errors++; $display("FAIL stall_hold[%0d] pc=%h instr=%h want 005/1005", i, b.pc_curr_if, b.instr_if);
      end
      if (i < 3) begin
        checks++;
        if (b.imem_en !== !gated || (!gated && b.imem_addr !== 10'h005)) begin
          errors++; $display("FAIL stall_mem[%0d] en=%b addr=%h want en=%b addr=005", i, b.imem_en, b.imem_addr, !gated);
        end
      end
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h006 || b.instr_if !== 16'h1006 || b.imem_en !== 1'b1) begin
      errors++; $display("FAIL stall_resume pc=%h instr=%h en=%b want 006/1006/1", b.pc_curr_if, b.instr_if, b.imem_en);
    end
  endtask
  task automatic test_redirect;
    tick(0, 1, 10'h02A);
    checks++;
    if (b.pc_curr_if !== 10'h007 || b.instr_if !== 16'h0000 || b.imem_addr !== 10'h02A) begin
      errors++; $display("FAIL redir_squash pc=%h instr=%h addr=%h want 007/0000/02A", b.pc_curr_if, b.instr_if, b.imem_addr);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h02A || b.instr_if !== 16'h102A) begin
      errors++; $display("FAIL redir_target pc=%h instr=%h want 02A/102A", b.pc_curr_if, b.instr_if);
    end
    tick(1, 1, 10'h040);
    checks++;
    if (b.pc_curr_if !== 10'h02B || b.instr_if !== 16'h0000 || b.imem_addr !== 10'h040 || b.imem_en !== 1'b1) begin
      errors++; $display("FAIL redir_stall pc=%h instr=%h addr=%h en=%b want 02B/0000/040/1", b.pc_curr_if, b.instr_if, b.imem_addr, b.imem_en);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h040 || b.instr_if !== 16'h1040) begin
      errors++; $display("FAIL redir_stall_target pc=%h instr=%h want 040/1040", b.pc_curr_if, b.instr_if);
    end
  endtask
  task automatic test_halt;
    tick(0, 1, 10'h008);
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h008 || b.instr_if !== 16'h1008) begin
      errors++; $display("FAIL pre_halt pc=%h instr=%h want 008/1008", b.pc_curr_if, b.instr_if);
    end
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, 0, 0);
      checks++;
      if (b.pc_curr_if !== 10'h009 || b.instr_if !== 16'hFFFF || b.halted !== 1'b0) begin
        errors++; $display("FAIL halt_pass[%0d] pc=%h instr=%h halted=%b want 009/FFFF/0", i, b.pc_curr_if, b.instr_if, b.halted);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(i == 0, 0, 0);
      checks++;
      if (b.halted !== 1'b1 || b.instr_if !== 16'h0000 || b.pc_curr_if !== 10'h009 || b.imem_en !== !gated || (!gated && b.imem_addr !== 10'h009)) begin
        errors++; $display("FAIL halted[%0d] halted=%b instr=%h pc=%h en=%b addr=%h want 1/0000/009/%b/009", i, b.halted, b.instr_if, b.pc_curr_if, b.imem_en, b.imem_addr, !gated);
      end
    end
    tick(0, 1, 10'h000);
    checks++;
    if (b.halted !== 1'b1 || b.instr_if !== 16'h0000 || b.imem_addr !== 10'h000 || b.imem_en !== 1'b1) begin
      errors++; $display("FAIL halt_redir halted=%b instr=%h addr=%h en=%b want 1/0000/000/1", b.halted, b.instr_if, b.imem_addr, b.imem_en);
    end
    tick(0, 0, 0);
    checks++;
    if (b.halted !== 1'b0 || b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h1000) begin
      errors++; $display("FAIL halt_exit halted=%b pc=%h instr=%h want 0/000/1000", b.halted, b.pc_curr_if, b.instr_if);
    end
  endtask
  task automatic test_wrap;
    tick(0, 1, 10'h3FF);
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h3FF || b.instr_if !== 16'h13FF) begin
      errors++; $display("FAIL wrap_top pc=%h instr=%h want 3FF/13FF", b.pc_curr_if, b.instr_if);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h1000) begin
      errors++; $display("FAIL wrap_zero pc=%h instr=%h want 000/1000", b.pc_curr_if, b.instr_if);
    end
  endtask
  task automatic test_mid_reset;
    tick(0, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (b.imem_addr !== 10'h000 || b.imem_en !== 1'b1) begin
      errors++; $display("FAIL mid_rst addr=%h en=%b want 000/1", b.imem_addr, b.imem_en);
    end
    @(negedge clk);
    rst = 0; b.redirect = 1; b.redirect_pc = 10'h055;
    #1;
    checks++;
    if (b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h0000 || b.imem_addr !== 10'h000) begin
      errors++; $display("FAIL boot_redir pc=%h instr=%h addr=%h want 000/0000/000", b.pc_curr_if, b.instr_if, b.imem_addr);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h000 || b.instr_if !== 16'h1000) begin
      errors++; $display("FAIL boot_ignore pc=%h instr=%h want 000/1000", b.pc_curr_if, b.instr_if);
    end
    tick(0, 0, 0);
    checks++;
    if (b.pc_curr_if !== 10'h001 || b.instr_if !== 16'h1001) begin
      errors++; $display("FAIL after_boot pc=%h instr=%h want 001/1001", b.pc_curr_if, b.instr_if);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 + 16'(i);
    rom[9] = 16'hFFFF;
    test_reset;
    test_stall;
    test_redirect;
    test_halt;
    test_wrap;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
